// File: rtl/mem_bus_bridge.sv
// Bridge from the single-cycle CPU memory strobe to a held valid/ready bus handshake.
// It registers the read data and reports completion or a watchdog abort as one-cycle pulses.
module mem_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_bus_error,
    output logic        busy,
    output logic        bus_valid,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned LIMIT_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LIMIT   = LIMIT_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic             WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] wdog_cnt_r;
    logic             timeout_s;
    logic [31:0]      cpu_rdata_r;
    logic [31:0]      bus_addr_r;
    logic [31:0]      bus_wdata_r;
    logic [3:0]       bus_wstrb_r;
    logic             cpu_ready_r;
    logic             cpu_bus_error_r;
    logic             busy_r;
    logic             bus_valid_r;

    // Watchdog limit detect; a zero limit parameter disables the abort path entirely.
    always_comb begin
        timeout_s = 1'b0;
        if (WDOG_EN) begin
            timeout_s = (wdog_cnt_r == LIMIT);
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next-state decode; bus_ready takes priority over the watchdog limit in REQ.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (cpu_valid) state_next_s = REQ;
                else           state_next_s = IDLE;
            end
            REQ: begin
                if (bus_ready)      state_next_s = RESP;
                else if (timeout_s) state_next_s = ERR;
                else                state_next_s = REQ;
            end
            RESP:    state_next_s = IDLE;
            ERR:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_next_s;
    end

    // Control outputs registered from the next state so they track state_r exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_valid_r     <= 1'b0;
            cpu_ready_r     <= 1'b0;
            cpu_bus_error_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            bus_valid_r     <= (state_next_s == REQ);
            cpu_ready_r     <= (state_next_s == RESP);
            cpu_bus_error_r <= (state_next_s == ERR);
            busy_r          <= (state_next_s != IDLE);
        end
    end

    // Payload capture, read-data capture and saturating watchdog counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_addr_r  <= 32'h0000_0000;
            bus_wdata_r <= 32'h0000_0000;
            bus_wstrb_r <= 4'b0000;
            cpu_rdata_r <= 32'h0000_0000;
            wdog_cnt_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu_valid) begin
                        bus_addr_r  <= cpu_addr;
                        bus_wdata_r <= cpu_wdata;
                        bus_wstrb_r <= cpu_wstrb;
                        wdog_cnt_r  <= '0;
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        // Stores leave the last read value in place.
                        if (bus_wstrb_r == 4'b0000) cpu_rdata_r <= bus_rdata;
                    end else if (timeout_s) begin
                        cpu_rdata_r <= 32'h0000_0000;
                    end else if (wdog_cnt_r != CNT_MAX) begin
                        wdog_cnt_r <= wdog_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cpu_rdata     = cpu_rdata_r;
    assign cpu_ready     = cpu_ready_r;
    assign cpu_bus_error = cpu_bus_error_r;
    assign busy          = busy_r;
    assign bus_valid     = bus_valid_r;
    assign bus_addr      = bus_addr_r;
    assign bus_wdata     = bus_wdata_r;
    assign bus_wstrb     = bus_wstrb_r;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: one instance with the default watchdog,
// one with a 4-cycle watchdog, both driven from the same stimulus.
module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    logic [31:0] cpu_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        cpu_ready, cpu_bus_error, busy, bus_valid;
    logic [31:0] t4_cpu_rdata, t4_bus_addr, t4_bus_wdata;
    logic [3:0]  t4_bus_wstrb;
    logic        t4_cpu_ready, t4_cpu_bus_error, t4_busy, t4_bus_valid;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    mem_bus_bridge dut (
        .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .cpu_bus_error(cpu_bus_error), .busy(busy),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    mem_bus_bridge #(.TIMEOUT_CYCLES(4)) dut_t4 (
        .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(t4_cpu_rdata),
        .cpu_ready(t4_cpu_ready), .cpu_bus_error(t4_cpu_bus_error), .busy(t4_busy),
        .bus_valid(t4_bus_valid), .bus_addr(t4_bus_addr), .bus_wdata(t4_bus_wdata),
        .bus_wstrb(t4_bus_wstrb), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; cpu_valid = 1'b0; bus_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({cpu_rdata, bus_addr, bus_wdata, bus_wstrb, cpu_ready, cpu_bus_error, bus_valid, busy} !== 104'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdata=%h addr=%h wdata=%h wstrb=%b rdy=%b err=%b vld=%b busy=%b, want all 0",
                     cpu_rdata, bus_addr, bus_wdata, bus_wstrb, cpu_ready, cpu_bus_error, bus_valid, busy);
        end
        checks++;
        if ({t4_cpu_rdata, t4_bus_valid, t4_busy, t4_cpu_ready, t4_cpu_bus_error} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs_t4: got rdata=%h vld=%b busy=%b, want 0", t4_cpu_rdata, t4_bus_valid, t4_busy);
        end
    endtask

    task automatic test_read();
        apply_reset();
        tick();
        cpu_valid = 1'b1; cpu_addr = 32'h1000_0004; cpu_wdata = 32'h0; cpu_wstrb = 4'b0000;
        exp_q.push_back(32'hCAFE_BABE);
        tick();
        cpu_valid = 1'b0;
        checks++;
        if (bus_valid !== 1'b1 || bus_addr !== 32'h1000_0004 || bus_wstrb !== 4'b0000) begin
            errors++;
            $display("FAIL read_req: got vld=%b addr=%h wstrb=%b, want 1 10000004 0000", bus_valid, bus_addr, bus_wstrb);
        end
        bus_ready = 1'b1; bus_rdata = 32'hCAFE_BABE;
        tick();
        bus_ready = 1'b0; bus_rdata = 32'h0;
        exp_v = exp_q.pop_front();
        checks++;
        if (cpu_ready !== 1'b1 || cpu_bus_error !== 1'b0 || cpu_rdata !== exp_v) begin
            errors++;
            $display("FAIL read_resp: got rdy=%b err=%b rdata=%h, want 1 0 %h", cpu_ready, cpu_bus_error, cpu_rdata, exp_v);
        end
        tick();
        checks++;
        if (cpu_ready !== 1'b0 || busy !== 1'b0 || bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: got rdy=%b busy=%b vld=%b, want 0 0 0", cpu_ready, busy, bus_valid);
        end
    endtask

    task automatic test_write_wait();
        int stable_bad;
        stable_bad = 0;
        cpu_valid = 1'b1; cpu_addr = 32'h2000_0000; cpu_wdata = 32'h1234_5678; cpu_wstrb = 4'b0011;
        exp_q.push_back(32'hCAFE_BABE);
        tick();
        cpu_valid = 1'b0; cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'hFFFF_FFFF; cpu_wstrb = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            if (bus_valid !== 1'b1 || bus_addr !== 32'h2000_0000 || bus_wdata !== 32'h1234_5678 ||
                bus_wstrb !== 4'b0011 || cpu_ready !== 1'b0) stable_bad++;
            tick();
        end
        checks++;
        if (stable_bad != 0) begin
            errors++;
            $display("FAIL write_stable: got %0d unstable wait cycles, want 0", stable_bad);
        end
        checks++;
        if (bus_valid !== 1'b1 || bus_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_ready_cycle: got vld=%b wdata=%h, want 1 12345678", bus_valid, bus_wdata);
        end
        bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_ready = 1'b0;
        exp_v = exp_q.pop_front();
        checks++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== exp_v) begin
            errors++;
            $display("FAIL write_resp: got rdy=%b rdata=%h, want 1 %h", cpu_ready, cpu_rdata, exp_v);
        end
        tick();
        checks++;
        if (cpu_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_single_pulse: got rdy=%b busy=%b, want 0 0", cpu_ready, busy);
        end
    endtask

    task automatic test_timeout();
        int vcnt;
        apply_reset();
        tick();
        cpu_valid = 1'b1; cpu_addr = 32'h3000_0000; cpu_wstrb = 4'b0000;
        tick();
        cpu_valid = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 20 && t4_bus_valid === 1'b1; i++) begin
            vcnt++;
            tick();
        end
        checks++;
        if (vcnt != 4) begin
            errors++;
            $display("FAIL timeout_valid_cycles: got %0d, want 4", vcnt);
        end
        checks++;
        if (t4_cpu_bus_error !== 1'b1 || t4_cpu_ready !== 1'b0 || t4_cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_error: got err=%b rdy=%b rdata=%h, want 1 0 0", t4_cpu_bus_error, t4_cpu_ready, t4_cpu_rdata);
        end
        tick();
        checks++;
        if (t4_busy !== 1'b0 || t4_cpu_bus_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%b err=%b, want 0 0", t4_busy, t4_cpu_bus_error);
        end
        checks++;
        if (bus_valid !== 1'b1 || cpu_bus_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_default_waits: got vld=%b err=%b, want 1 0", bus_valid, cpu_bus_error);
        end
    endtask

    task automatic test_boundary();
        int bad;
        bad = 0;
        apply_reset();
        tick();
        cpu_valid = 1'b1; cpu_addr = 32'h4000_0000; cpu_wstrb = 4'b0000;
        tick();
        cpu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (t4_bus_valid !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0 || t4_bus_valid !== 1'b1) begin
            errors++;
            $display("FAIL boundary_valid: got %0d gaps, vld=%b on 4th cycle, want 0 1", bad, t4_bus_valid);
        end
        bus_ready = 1'b1; bus_rdata = 32'h0BAD_F00D;
        tick();
        bus_ready = 1'b0;
        checks++;
        if (t4_cpu_ready !== 1'b1 || t4_cpu_bus_error !== 1'b0 || t4_cpu_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL boundary_ready_wins: got rdy=%b err=%b rdata=%h, want 1 0 0badf00d",
                     t4_cpu_ready, t4_cpu_bus_error, t4_cpu_rdata);
        end
        tick();
        checks++;
        if (t4_cpu_bus_error !== 1'b0 || t4_busy !== 1'b0) begin
            errors++;
            $display("FAIL boundary_no_late_error: got err=%b busy=%b, want 0 0", t4_cpu_bus_error, t4_busy);
        end
    endtask

    task automatic test_back_to_back();
        int n_req, n_rdy, bad;
        logic prev_vld;
        n_req = 0; n_rdy = 0; bad = 0; prev_vld = 1'b0;
        apply_reset();
        for (int c = 0; c < 14; c++) begin
            tick();
            cpu_valid = (c < 10); cpu_addr = 32'(c * 4); cpu_wstrb = 4'b0000;
            bus_ready = 1'b1; bus_rdata = 32'hA000_0000 + 32'(c);
            if (c % 3 == 1 && c <= 10) exp_q.push_back(32'hA000_0000 + 32'(c));
            if (bus_valid === 1'b1) begin
                n_req++;
                if (prev_vld === 1'b1 || bus_addr !== 32'((c - 1) * 4)) bad++;
            end
            if (cpu_ready === 1'b1) begin
                n_rdy++;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
                checks++;
                if (cpu_rdata !== exp_v) begin
                    errors++;
                    $display("FAIL b2b_rdata: cycle %0d got %h, want %h", c, cpu_rdata, exp_v);
                end
            end
            prev_vld = bus_valid;
        end
        cpu_valid = 1'b0; bus_ready = 1'b0;
        checks++;
        if (n_req != 4 || n_rdy != 4 || bad != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got req=%0d rdy=%0d bad=%0d left=%0d, want 4 4 0 0", n_req, n_rdy, bad, exp_q.size());
        end
    endtask

    task automatic test_reset_in_req();
        int lat;
        apply_reset();
        tick();
        cpu_valid = 1'b1; cpu_addr = 32'h5000_0000; cpu_wstrb = 4'b0000;
        tick();
        cpu_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus_valid !== 1'b0 || busy !== 1'b0 || cpu_ready !== 1'b0 || cpu_bus_error !== 1'b0 || bus_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_in_req: got vld=%b busy=%b rdy=%b err=%b addr=%h, want 0 0 0 0 0",
                     bus_valid, busy, cpu_ready, cpu_bus_error, bus_addr);
        end
        tick();
        checks++;
        if (cpu_ready !== 1'b0 || cpu_bus_error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse: got rdy=%b err=%b busy=%b, want 0 0 0", cpu_ready, cpu_bus_error, busy);
        end
        cpu_valid = 1'b1; cpu_addr = 32'h6000_0008; cpu_wstrb = 4'b0000;
        exp_q.push_back(32'h5555_AAAA);
        tick();
        cpu_valid = 1'b0;
        bus_ready = 1'b1; bus_rdata = 32'h5555_AAAA;
        lat = 1;
        for (int i = 0; i < 10 && cpu_ready !== 1'b1; i++) begin
            tick();
            bus_ready = 1'b0;
            lat++;
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (cpu_ready !== 1'b1 || lat != 2 || cpu_rdata !== exp_v) begin
            errors++;
            $display("FAIL post_reset_read: got rdy=%b latency=%0d rdata=%h, want 1 2 %h", cpu_ready, lat, cpu_rdata, exp_v);
        end
    endtask

    initial begin
        cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_wstrb = 4'b0000; bus_rdata = 32'h0;
        test_reset();
        test_read();
        test_write_wait();
        test_timeout();
        test_boundary();
        test_back_to_back();
        test_reset_in_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
